// File: rtl/seqpu_core_p.sv
// seqpu_core_p: parametrised accumulator CPU core sharing one wait-stated memory port
module seqpu_core_p #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] RESET_SP = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             wren_n,
  output logic             oen_n,
  input  logic             mem_ready,
  output logic [1:0]       state_o,
  output logic [WIDTH-1:0] pc_o,
  output logic             carry_o
);
  localparam int R = $clog2(WIDTH);
  localparam logic [R:0] WL = WIDTH[R:0];
  localparam logic [1:0] FETCH = 2'd0, EXECUTE = 2'd1, LOAD = 2'd2, ALU = 2'd3;
  logic [1:0] state, cls, dst;
  logic [2:0] alu;
  logic [R-1:0] k;
  logic [WIDTH-1:0] pc, sp, a, b, op, res, rot_res;
  logic [WIDTH:0] sum;
  logic carry, c, store, wr_dst;
  assign cls = op[WIDTH-1:WIDTH-2];
  assign dst = op[WIDTH-3:WIDTH-4];
  assign alu = op[WIDTH-5:WIDTH-7];
  assign k = op[R-1:0];
  assign wr_dst = cls[1];
  assign store = state == EXECUTE && cls == 2'b01 && !op[WIDTH-3];
  assign address = (store || state == LOAD) ? sp : pc;
  assign data_out = a;
  assign wren_n = rst || !store;
  assign oen_n = rst || !(state == FETCH || state == LOAD);
  assign state_o = state;
  assign pc_o = pc;
  assign carry_o = carry;
  assign sum = {1'b0, a} + {1'b0, b};
  // low k bits of the rotated result are refilled from the old accumulator's top bits
  assign rot_res = k == '0 ? res : (res << k) | (a >> (WL - {1'b0, k}));
  always_comb begin
    res = '0;
    c = 1'b0;
    case (alu)
      3'd0: begin res = sum[WIDTH-1:0]; c = sum[WIDTH]; end
      3'd1: begin res = a - b; c = a >= b; end
      3'd2: begin res = a | b; c = |a; end
      3'd3: begin res = a & b; c = &a; end
      3'd4: begin res = a ^ b; c = ^a; end
      3'd5: begin res = b; c = a == b; end
      3'd6: begin res = a; c = a > b; end
      default: begin res = '0; c = 1'b0; end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      sp <= RESET_SP;
      a <= '0;
      b <= '0;
      op <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          op <= data_in;
          state <= EXECUTE;
        end
        EXECUTE: begin
          if (cls == 2'b00) b <= {2'b00, op[WIDTH-3:0]};
          if (cls == 2'b11) b <= {{(WIDTH-9){op[8]}}, op[8:0]};
          state <= cls != 2'b01 ? ALU : op[WIDTH-3] ? LOAD : mem_ready ? ALU : EXECUTE;
        end
        LOAD: if (mem_ready) begin
          b <= data_in;
          state <= ALU;
        end
        default: begin
          state <= FETCH;
          pc <= wr_dst && dst == 2'b10 ? res : pc + 1'b1;
          if (wr_dst && dst == 2'b00) begin
            a <= res;
            carry <= c;
          end
          if (wr_dst && dst == 2'b01) sp <= res;
          if (wr_dst && dst == 2'b11) a <= rot_res;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seqpu_core_p.sv
// tb_seqpu_core_p: directed program with a scoreboard of expected memory transactions
module tb_seqpu_core_p;
  typedef struct {
    logic [1:0]  st;
    logic [15:0] addr;
    logic [15:0] data;
    logic        c;
    int          held;
    int          gap;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
  logic [15:0] address, data_in, data_out, pc_o;
  logic wren_n, oen_n, carry_o;
  logic [1:0] state_o;
  logic [15:0] mem [0:65535];
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, held = 0, cyc = 0, last = 0;
  logic was_rst = 1'b0, done_req = 1'b0, drained = 1'b0;

  always #5 clk = ~clk;
  assign data_in = mem[address];

  seqpu_core_p dut (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in), .data_out(data_out),
    .wren_n(wren_n), .oen_n(oen_n), .mem_ready(mem_ready), .state_o(state_o),
    .pc_o(pc_o), .carry_o(carry_o)
  );

  task automatic chk(string n, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, act, want, cyc);
    end
  endtask

  task automatic ex(logic [1:0] st, logic [15:0] addr, logic [15:0] data, logic c, int h, int g);
    exp_t t;
    t.st = st; t.addr = addr; t.data = data; t.c = c; t.held = h; t.gap = g;
    q.push_back(t);
  endtask

  // memory responder and monitor: stalls per the head entry, then compares on completion
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_state", 32'(state_o), 0);
      chk("rst_pc", 32'(pc_o), 0);
      chk("rst_wren_n", 32'(wren_n), 1);
      chk("rst_oen_n", 32'(oen_n), 1);
      mem_ready = 1'b0; held = 0; cyc = 0; last = 0; was_rst = 1'b1;
    end else begin
      if (was_rst) begin
        chk("release_addr", 32'(address), 0);
        chk("release_oen_n", 32'(oen_n), 0);
        was_rst = 1'b0;
      end
      chk("one_strobe", 32'(wren_n | oen_n), 1);
      cyc++;
      mem_ready = 1'b0;
      if ((!wren_n || !oen_n) && q.size() > 0) begin
        e = q[0];
        if (held + 1 < e.held) held++;
        else begin
          mem_ready = 1'b1;
          void'(q.pop_front());
          chk("state", 32'(state_o), 32'(e.st));
          chk("addr", 32'(address), 32'(e.addr));
          chk("wren_n", 32'(wren_n), e.st == 2'd1 ? 0 : 1);
          chk("carry", 32'(carry_o), 32'(e.c));
          chk("held", held + 1, e.held);
          if (e.st == 2'd0) chk("pc", 32'(pc_o), 32'(e.addr));
          if (e.st == 2'd1) chk("store_data", 32'(data_out), 32'(e.data));
          if (e.gap != 0) chk("gap", cyc - last, e.gap);
          held = 0;
          last = cyc;
        end
      end
      if (done_req && !drained) begin
        chk("drain", q.size(), 0);
        drained = 1'b1;
      end
    end
  end

  initial begin
    mem[16'h0000] = 16'h1234; mem[16'h0001] = 16'hAA00;
    mem[16'h1234] = 16'hC1FF; mem[16'h1235] = 16'hDA80; mem[16'h1236] = 16'h4000;
    mem[16'h1237] = 16'hC001; mem[16'h1238] = 16'h4000; mem[16'h1239] = 16'hDA81;
    mem[16'h123A] = 16'h6000; mem[16'h123B] = 16'h8800; mem[16'h123C] = 16'h4000;
    mem[16'h123D] = 16'hDA82; mem[16'h123E] = 16'h6000; mem[16'h123F] = 16'h8A00;
    mem[16'h1240] = 16'h8A00; mem[16'h1241] = 16'hBC04; mem[16'h1242] = 16'h4000;
    mem[16'h1243] = 16'hEA20; mem[16'h0020] = 16'hEBFF; mem[16'hFFFF] = 16'h0000;
    mem[16'h0081] = 16'h5A5A; mem[16'h0082] = 16'h8001;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    ex(0, 16'h0000, 0, 0, 1, 0);
    ex(0, 16'h0001, 0, 0, 1, 3);
    ex(0, 16'h1234, 0, 0, 1, 3);
    ex(0, 16'h1235, 0, 0, 1, 3);
    ex(0, 16'h1236, 0, 0, 1, 3);
    ex(1, 16'h0080, 16'hFFFF, 0, 4, 4);
    ex(0, 16'h1237, 0, 0, 1, 2);
    ex(0, 16'h1238, 0, 1, 1, 3);
    ex(1, 16'h0080, 16'h0000, 1, 1, 1);
    ex(0, 16'h1239, 0, 1, 1, 2);
    ex(0, 16'h123A, 0, 1, 1, 3);
    ex(2, 16'h0081, 0, 1, 1, 2);
    ex(0, 16'h123B, 0, 1, 1, 2);
    ex(0, 16'h123C, 0, 0, 1, 3);
    ex(1, 16'h0081, 16'h5A5A, 0, 1, 1);
    ex(0, 16'h123D, 0, 0, 1, 2);
    ex(0, 16'h123E, 0, 0, 1, 3);
    ex(2, 16'h0082, 0, 0, 1, 2);
    ex(0, 16'h123F, 0, 0, 1, 2);
    ex(0, 16'h1240, 0, 0, 1, 3);
    ex(0, 16'h1241, 0, 1, 1, 3);
    ex(0, 16'h1242, 0, 1, 1, 3);
    ex(1, 16'h0082, 16'h0018, 1, 1, 1);
    ex(0, 16'h1243, 0, 1, 1, 2);
    ex(0, 16'h0020, 0, 1, 1, 3);
    ex(0, 16'hFFFF, 0, 1, 1, 3);
    ex(0, 16'h0000, 0, 1, 1, 3);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 500 && q.size() > 0; i++) @(posedge clk);
    done_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seqpu_core_p.md
Name: seqpu_core_p

Overview:
- Parametrised next-generation sequential accumulator CPU core: FETCH/EXECUTE/LOAD/ALU micro-sequence over a single shared memory port.
- Generalises data/instruction width to WIDTH.
- Adds a mem_ready wait-state handshake, so the core runs from slow or shared SRAM.
- Adds selectable ALU destination (A, SP, PC, or A with rotate) and exposes debug state.

Parameters:
- WIDTH, 16, data, address and instruction width; even, ≥16.
- RESET_PC, 0, PC value after reset.
- RESET_SP, 0, SP value after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- address  out  WIDTH  memory address.
- data_in  in  WIDTH  read data; sampled in the cycle mem_ready=1.
- data_out  out  WIDTH  write data.
- wren_n  out  1  write strobe, active-low.
- oen_n  out  1  read enable, active-low.
- mem_ready  in  1  access completes in any cycle where it is high while a strobe is low.
- state_o  out  2  0=FETCH, 1=EXECUTE, 2=LOAD, 3=ALU.
- pc_o  out  WIDTH  current PC.
- carry_o  out  1  carry flag.

Behaviour:
- Reset (while rst=1, next edge):
  - state=FETCH, pc=RESET_PC, sp=RESET_SP, a=b=op=0, carry=0.
  - While rst=1, wren_n=oen_n=1 are forced combinationally.
  - rst mid-access aborts the access; there is no partial register write.
- Invariant: wren_n|oen_n=1 in every cycle. Strobes and address are combinational from state.
- Instruction fields, with R=log2(WIDTH) (16-bit positions in brackets):
  - cls=op[W-1:W-2] [15:14]
  - dst=op[W-3:W-4] [13:12]
  - alu=op[W-5:W-7] [11:9]
  - lit9=op[8:0]
  - rot=op[R-1:0] [3:0]
- FETCH:
  - address=pc, oen_n=0.
  - Stays in FETCH while mem_ready=0.
  - When mem_ready=1: op<=data_in, go to EXECUTE.
- EXECUTE:
  - cls=00: b<=zero-extended op[W-3:0]; go to ALU.
  - cls=01, op[W-3]=0 (store): address=sp, data_out=a, wren_n=0. Hold until mem_ready=1, then go to ALU.
  - cls=01, op[W-3]=1 (load): go to LOAD.
  - cls=10: no access; go to ALU.
  - cls=11: b<=sign-extended lit9; go to ALU.
- LOAD:
  - address=sp, oen_n=0.
  - When mem_ready=1: b<=data_in, go to ALU.
- ALU: one cycle, no strobes, then FETCH. Only cls 1x writes a destination.
  - res (by alu): 000 a+b, 001 a-b, 010 a|b, 011 a&b, 100 a^b, 101 b, 110 a, 111 0.
  - c (by alu): 000 carry-out of (W+1)-bit a+b; 001 a≥b; 010 |a; 011 &a; 100 ^a; 101 a==b; 110 a>b; 111 0.
  - dst=00: a<=res, carry<=c.
  - dst=01: sp<=res.
  - dst=10: pc<=res (jump, no increment).
  - dst=11: a<={res[W-1-k:0], a[W-1:W-k]} with k=rot; k=0 gives res.
  - Every case except dst=10 does pc<=pc+1, modulo 2^WIDTH (wraps to 0).
  - carry changes only when cls is 1x and dst=00.
- Latency with mem_ready tied high:
  - 3 cycles per instruction for cls 00, 01-store, 10, 11.
  - 4 cycles per instruction for load.
  - Each mem_ready=0 cycle adds one cycle.

Test Plan:
- Reset: hold rst=1 for 2 cycles, with rst=1 at an edge during a FETCH wait → state_o=0, pc_o=0, wren_n=oen_n=1; after release, address=0 and oen_n=0.
- Literal: mem[0]=0x1234, mem_ready=1 → states 0,1,3,0; b=0x1234; next fetch address=1.
- Add/carry: 0xC1FF then 0xC001 with a=0 → a=0xFFFF, carry=0; then a=0x0000, carry=1.
- Store with waits:
  - 0xDA80 sets sp=0x0080.
  - Store 0x4000 with mem_ready low for 3 cycles → wren_n=0, address=0x0080, data_out=a held 4 cycles.
  - State stays 1 throughout, then 3.
  - oen_n=1 for the whole store.
- Jump: 0xEA20 → pc=0x0020; next FETCH address=0x0020.
- Rotate: a=0x8001, instruction 0xBC04 → a=0x0018, carry unchanged.
